// File: rtl/io_unit_if.sv
// Bundle of the syscall request/response and host stream signals shared
// between the instruction controller / host side and the io_unit.
interface io_unit_if #(
   parameter int WIDTH = 16
);
   // controller request / response
   logic             runio;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] dr;
   logic             iobusy;
   logic [WIDTH-1:0] io_result;
   logic             halted;

   // host input stream
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;

   // host output stream
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   // controller/host side
   modport master (
      output runio, acc, dr, in_valid, in_data, out_ready,
      input  iobusy, io_result, halted, in_ready, out_valid, out_data
   );

   // io_unit side
   modport slave (
      input  runio, acc, dr, in_valid, in_data, out_ready,
      output iobusy, io_result, halted, in_ready, out_valid, out_data
   );
endinterface

// File: rtl/io_unit.sv
// Syscall execution unit: takes a runio request with ACC (code) and DR
// (argument), runs HALT / READ / WRITE over ready/valid host streams and
// returns the result for the ACC IO mux.
module io_unit #(
   parameter int WIDTH = 16
) (
   input  logic     clock,
   input  logic     reset,
   io_unit_if.slave bus
);

   localparam logic [WIDTH-1:0] CODE_HALT  = WIDTH'(0);
   localparam logic [WIDTH-1:0] CODE_READ  = WIDTH'(1);
   localparam logic [WIDTH-1:0] CODE_WRITE = WIDTH'(2);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      HALT  = 3'd4
   } state_t;

   state_t           state, state_nx;
   logic             rd_ready, rd_ready_nx;
   logic             wr_valid, wr_valid_nx;
   logic [WIDTH-1:0] wr_data, wr_data_nx;
   logic [WIDTH-1:0] result, result_nx;
   logic             halt_flag, halt_flag_nx;

   // iobusy is decoded straight from state so the controller sees it in the
   // same cycle runio rises; HALT keeps it asserted for good.
   assign bus.iobusy    = (bus.runio && (state != DONE)) || (state == HALT);
   assign bus.in_ready  = rd_ready;
   assign bus.out_valid = wr_valid;
   assign bus.out_data  = wr_data;
   assign bus.io_result = result;
   assign bus.halted    = halt_flag;

   // Next-state and next-register-value decode.
   always_comb begin
      state_nx     = state;
      rd_ready_nx  = rd_ready;
      wr_valid_nx  = wr_valid;
      wr_data_nx   = wr_data;
      result_nx    = result;
      halt_flag_nx = halt_flag;

      case (state)
         IDLE: begin
            rd_ready_nx = 1'b0;
            wr_valid_nx = 1'b0;
            if (bus.runio) begin
               if (bus.acc == CODE_HALT) begin
                  state_nx     = HALT;
                  halt_flag_nx = 1'b1;
               end else if (bus.acc == CODE_READ) begin
                  state_nx    = READ;
                  rd_ready_nx = 1'b1;
               end else if (bus.acc == CODE_WRITE) begin
                  // wr_data doubles as the latched DR, so later DR
                  // changes cannot disturb the word or the result.
                  state_nx    = WRITE;
                  wr_data_nx  = bus.dr;
                  wr_valid_nx = 1'b1;
               end else begin
                  state_nx  = DONE;
                  result_nx = {WIDTH{1'b1}};
               end
            end
         end

         READ: begin
            if (bus.in_valid && rd_ready) begin
               result_nx   = bus.in_data;
               rd_ready_nx = 1'b0;
               state_nx    = DONE;
            end
         end

         WRITE: begin
            if (wr_valid && bus.out_ready) begin
               wr_valid_nx = 1'b0;
               result_nx   = wr_data;
               state_nx    = DONE;
            end
         end

         DONE: begin
            // Wait for runio to drop so a held request is not re-issued.
            rd_ready_nx = 1'b0;
            wr_valid_nx = 1'b0;
            if (!bus.runio) begin
               state_nx = IDLE;
            end
         end

         HALT: begin
            rd_ready_nx  = 1'b0;
            wr_valid_nx  = 1'b0;
            halt_flag_nx = 1'b1;
         end

         default: begin
            state_nx    = IDLE;
            rd_ready_nx = 1'b0;
            wr_valid_nx = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         rd_ready  <= 1'b0;
         wr_valid  <= 1'b0;
         wr_data   <= '0;
         result    <= '0;
         halt_flag <= 1'b0;
      end else begin
         state     <= state_nx;
         rd_ready  <= rd_ready_nx;
         wr_valid  <= wr_valid_nx;
         wr_data   <= wr_data_nx;
         result    <= result_nx;
         halt_flag <= halt_flag_nx;
      end
   end

endmodule

// File: tb/tb_io_unit.sv
// Directed bench for io_unit: reset, READ, WRITE with backpressure,
// ILLEGAL, READ with late data, reset mid-WRITE and HALT.
module tb_io_unit;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_fails;
   int   xfers;

   io_unit_if #(.WIDTH(16)) bus ();

   io_unit #(.WIDTH(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // count completed output handshakes seen at non-reset edges
   always @(posedge clock) begin
      if (reset && bus.out_valid && bus.out_ready) xfers <= xfers + 1;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      xfers    = 0;
      reset         = 1'b0;
      bus.runio     = 1'b1;
      bus.acc       = 16'd1;
      bus.dr        = 16'h0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 16'h0;
      bus.out_ready = 1'b0;

      // reset held two cycles with a READ request pending
      tick();
      tick();
      check("rst_in_ready",  32'(bus.in_ready),  32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_io_result", 32'(bus.io_result), 32'h0);
      check("rst_halted",    32'(bus.halted),    32'd0);
      check("rst_out_data",  32'(bus.out_data),  32'h0);
      bus.runio = 1'b0;
      reset     = 1'b1;
      #1;
      check("rst_iobusy", 32'(bus.iobusy), 32'd0);
      tick();
      check("idle_in_ready", 32'(bus.in_ready), 32'd0);
      check("idle_iobusy",   32'(bus.iobusy),   32'd0);

      // READ with data already waiting
      bus.acc      = 16'd1;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h1234;
      bus.runio    = 1'b1;
      #1;
      check("rd_busy_now", 32'(bus.iobusy), 32'd1);
      tick();
      check("rd_in_ready", 32'(bus.in_ready), 32'd1);
      check("rd_busy1",    32'(bus.iobusy),   32'd1);
      tick();
      check("rd_done_busy",  32'(bus.iobusy),    32'd0);
      check("rd_result",     32'(bus.io_result), 32'h1234);
      check("rd_in_ready_0", 32'(bus.in_ready),  32'd0);
      bus.runio    = 1'b0;
      bus.in_valid = 1'b0;
      tick();

      // WRITE with five cycles of backpressure
      bus.acc       = 16'd2;
      bus.dr        = 16'hBEEF;
      bus.out_ready = 1'b0;
      bus.runio     = 1'b1;
      #1;
      check("wr_busy_now", 32'(bus.iobusy), 32'd1);
      tick();
      bus.acc = 16'd5;
      bus.dr  = 16'h0000;
      for (int i = 0; i < 5; i++) begin
         check("wr_hold_valid", 32'(bus.out_valid), 32'd1);
         check("wr_hold_data",  32'(bus.out_data),  32'hBEEF);
         check("wr_hold_busy",  32'(bus.iobusy),    32'd1);
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      check("wr_last_valid", 32'(bus.out_valid), 32'd1);
      check("wr_last_data",  32'(bus.out_data),  32'hBEEF);
      check("wr_last_busy",  32'(bus.iobusy),    32'd1);
      tick();
      check("wr_done_valid",  32'(bus.out_valid), 32'd0);
      check("wr_done_result", 32'(bus.io_result), 32'hBEEF);
      check("wr_done_busy",   32'(bus.iobusy),    32'd0);
      tick();
      check("wr_no_reissue", 32'(bus.out_valid), 32'd0);
      check("wr_one_xfer",   32'(xfers),         32'd1);
      bus.runio     = 1'b0;
      bus.out_ready = 1'b0;
      tick();

      // ILLEGAL code, runio held high afterwards
      bus.acc   = 16'h0007;
      bus.runio = 1'b1;
      tick();
      check("ill_busy",   32'(bus.iobusy),    32'd0);
      check("ill_result", 32'(bus.io_result), 32'hFFFF);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ill_hold_busy",   32'(bus.iobusy),    32'd0);
         check("ill_hold_result", 32'(bus.io_result), 32'hFFFF);
         check("ill_hold_streams", 32'({bus.in_ready, bus.out_valid}), 32'd0);
      end
      bus.runio = 1'b0;
      tick();

      // READ with late data and runio dropped mid-transfer
      bus.acc      = 16'd1;
      bus.in_valid = 1'b0;
      bus.runio    = 1'b1;
      tick();
      bus.runio = 1'b0;
      #1;
      check("rd2_busy_dropped", 32'(bus.iobusy), 32'd0);
      tick();
      tick();
      check("rd2_wait_ready",  32'(bus.in_ready),  32'd1);
      check("rd2_hold_result", 32'(bus.io_result), 32'hFFFF);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hABCD;
      tick();
      bus.in_valid = 1'b0;
      check("rd2_result",   32'(bus.io_result), 32'hABCD);
      check("rd2_in_ready", 32'(bus.in_ready),  32'd0);
      tick();
      bus.runio = 1'b1;
      bus.acc   = 16'd2;
      bus.dr    = 16'h1111;
      #1;
      check("rd2_back_idle", 32'(bus.iobusy), 32'd1);

      // reset while a WRITE is stalled
      tick();
      check("rw_valid", 32'(bus.out_valid), 32'd1);
      check("rw_data",  32'(bus.out_data),  32'h1111);
      reset = 1'b0;
      tick();
      check("rw_valid_cleared", 32'(bus.out_valid), 32'd0);
      check("rw_data_cleared",  32'(bus.out_data),  32'h0);
      check("rw_result_reset",  32'(bus.io_result), 32'h0);
      reset     = 1'b1;
      bus.runio = 1'b0;
      #1;
      check("rw_idle_busy", 32'(bus.iobusy), 32'd0);
      tick();
      check("rw_still_idle", 32'(bus.out_valid), 32'd0);
      check("rw_no_xfer",    32'(xfers),         32'd1);

      // HALT persists through stream activity until reset
      bus.acc   = 16'd0;
      bus.runio = 1'b1;
      tick();
      check("halt_flag", 32'(bus.halted), 32'd1);
      check("halt_busy", 32'(bus.iobusy), 32'd1);
      bus.runio = 1'b0;
      for (int i = 0; i < 20; i++) begin
         bus.in_valid  = i[0];
         bus.out_ready = ~i[0];
         tick();
         check("halt_hold_flag", 32'(bus.halted), 32'd1);
         check("halt_hold_busy", 32'(bus.iobusy), 32'd1);
         check("halt_no_stream", 32'({bus.in_ready, bus.out_valid}), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      reset = 1'b0;
      tick();
      check("halt_rst_flag", 32'(bus.halted), 32'd0);
      check("halt_rst_busy", 32'(bus.iobusy), 32'd0);
      reset = 1'b1;
      tick();
      check("final_xfers", 32'(xfers), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
